id_unit: RTL and testbench
==========================

ID_UNIT -- requirements
Module: id_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 instr_in  input  20  instruction delivered by the fetch stage, valid every cycle.
REQ-004 npc_in  input  8  next-PC paired with instr_in.
REQ-005 wb_en  input  1  register-file write enable from writeback.
REQ-006 wb_addr  input  4  writeback destination register.
REQ-007 wb_data  input  8  writeback data.
REQ-008 jump_selector  output  1  redirect request to fetch, one-cycle pulse.
REQ-009 jump_address  output  8  redirect target, valid while jump_selector=1.
REQ-010 ex_valid  output  1  ID/EX register holds a live instruction.
REQ-011 ex_op  output  4  decoded opcode.
REQ-012 ex_rd  output  4  destination register.
REQ-013 ex_a  output  8  operand A (rs1 value).
REQ-014 ex_b  output  8  operand B (rs2 value, or imm8 for ADDI/LD/ST).
REQ-015 ex_sdata  output  8  store data (ST only, else 0).
REQ-016 ex_npc  output  8  npc_in captured with the instruction.
REQ-017 illegal  output  1  registered one-cycle flag, reserved opcode captured.

Function
REQ-018 Format: op=[19:16]; R-type rd=[15:12] rs1=[11:8] rs2=[7:4]; I-type rd=[15:12] rs1=[11:8] imm8=[7:0]; ST src=[15:12]; JMP/BEQZ rs1=[11:8] target=[7:0].
REQ-019 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 JMP, 9 BEQZ; 10-15 reserved.
REQ-020 Register file 16x8; r0 reads 0 always; writes to r0 ignored; write at posedge when wb_en=1.
REQ-021 Every posedge the ID/EX register captures the decode of instr_in/npc_in; latency 1 cycle, no stall.
REQ-022 JMP: next cycle jump_selector=1, jump_address=target, for exactly one cycle.
REQ-023 BEQZ: taken iff rs1 value==0 (after bypass); taken behaves as JMP; not taken produces no pulse.
REQ-024 JMP/BEQZ captured with ex_valid=1, ex_op=op, ex_rd=0; never write a register.
REQ-025 Squash: instruction present while jump_selector=1 is captured as NOP, ex_valid=0; a JMP/BEQZ/reserved op in that slot produces no pulse and no illegal.
REQ-026 Reserved opcode: captured as NOP with ex_valid=0; illegal=1 next cycle for one cycle.
REQ-027 NOP captured with ex_valid=0, all ex_* fields 0 except ex_npc.
REQ-028 Back-to-back jumps: second jump sits in squash slot and is discarded (REQ-025).

Reset
REQ-029 rst_n=0 asynchronously clears: jump_selector, jump_address, illegal, ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_sdata, ex_npc to 0, and all 16 registers to 0.
REQ-030 Reset asserted mid-jump-pulse clears the pulse and the pending squash; first instruction after release decodes normally.
REQ-031 wb_en ignored while rst_n=0.

Configuration
REQ-032 Macro ID_BYPASS_EN defined: a read whose address equals wb_addr with wb_en=1 and wb_addr!=0 returns wb_data in the same cycle (write-first).
REQ-033 ID_BYPASS_EN undefined: reads return register contents before the concurrent write; BEQZ evaluates the old value.

Verification
REQ-034 Reset, then wb r3<=8'h2A, then instr ADD rd=1 rs1=3 rs2=0 -> ex_valid=1, ex_op=1, ex_rd=1, ex_a=8'h2A, ex_b=0.
REQ-035 JMP target=8'd12 at npc=5 -> next cycle jump_selector=1, jump_address=12 one cycle; following instr (npc=6) captured ex_valid=0.
REQ-036 r2=0, BEQZ rs1=2 target=8'd40 -> pulse to 40; r2=7 same instr -> no pulse, ex_valid=1.
REQ-037 wb_en=1 wb_addr=4 wb_data=8'h00 same cycle as BEQZ rs1=4 (r4 was 5) -> taken with ID_BYPASS_EN, not taken without.
REQ-038 instr op=4'hC -> illegal=1 one cycle, ex_valid=0; same op in squash slot -> illegal stays 0.
REQ-039 rst_n low while jump_selector=1 -> all outputs 0 immediately; after release ADDI rd=1 rs1=0 imm=8'h05 -> ex_b=8'h05, ex_valid=1.

Source files
------------

// File: rtl/id_unit_if.sv
// id_unit_if: bundles the fetch, writeback and ID/EX signals of the
// instruction-decode stage. The slave modport is the decode unit itself;
// the master modport is whatever feeds it (fetch/writeback) and consumes
// its ID/EX register and redirect outputs.
interface id_unit_if;
    // fetch and writeback side
    logic [19:0] instr_in;
    logic [7:0]  npc_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [7:0]  wb_data;
    // redirect to fetch
    logic        jump_selector;
    logic [7:0]  jump_address;
    // ID/EX register
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic [7:0]  ex_a;
    logic [7:0]  ex_b;
    logic [7:0]  ex_sdata;
    logic [7:0]  ex_npc;
    logic        illegal;

    modport master (
        output instr_in, npc_in, wb_en, wb_addr, wb_data,
        input  jump_selector, jump_address, ex_valid, ex_op, ex_rd,
               ex_a, ex_b, ex_sdata, ex_npc, illegal
    );

    modport slave (
        input  instr_in, npc_in, wb_en, wb_addr, wb_data,
        output jump_selector, jump_address, ex_valid, ex_op, ex_rd,
               ex_a, ex_b, ex_sdata, ex_npc, illegal
    );
endinterface

// File: rtl/id_unit.sv
// id_unit: instruction decode stage with a 16x8 register file.
// Decodes one 20-bit instruction per cycle into the ID/EX register,
// resolves JMP/BEQZ here and raises a one-cycle redirect pulse, squashing
// the instruction that sits in the slot behind a taken jump.
// Optional feature: define ID_BYPASS_EN to forward the concurrent
// writeback value to register reads (write-first); undefined, reads see
// the register contents before the write.
module id_unit (
    input  logic   clk,
    input  logic   rst_n,
    id_unit_if.slave bus
);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;

    // register file; must be flops since reset clears every entry
    logic [7:0] regs_reg [16];

    // three read ports: 0 = rs1 [11:8], 1 = rs2 [7:4], 2 = store source [15:12]
    logic [3:0] rd_addr [3];
    logic [7:0] rd_val  [3];

    assign rd_addr[0] = bus.instr_in[11:8];
    assign rd_addr[1] = bus.instr_in[7:4];
    assign rd_addr[2] = bus.instr_in[15:12];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_read
`ifdef ID_BYPASS_EN
            // r0 is hard zero; otherwise a same-cycle writeback wins
            assign rd_val[gi] = (rd_addr[gi] == 4'd0) ? 8'h00 :
                                (bus.wb_en && (bus.wb_addr == rd_addr[gi])) ? bus.wb_data :
                                regs_reg[rd_addr[gi]];
`else
            // r0 is hard zero; otherwise the value stored before this edge
            assign rd_val[gi] = (rd_addr[gi] == 4'd0) ? 8'h00 : regs_reg[rd_addr[gi]];
`endif
        end
    endgenerate

    // writeback into the register file; r0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_reg[i] <= 8'h00;
            end
        end else if (bus.wb_en && (bus.wb_addr != 4'd0)) begin
            regs_reg[bus.wb_addr] <= bus.wb_data;
        end
    end

    logic       jump_sel_reg, jump_sel_next;
    logic [7:0] jump_addr_reg, jump_addr_next;
    logic       illegal_reg, illegal_next;
    logic       ex_valid_reg, ex_valid_next;
    logic [3:0] ex_op_reg, ex_op_next;
    logic [3:0] ex_rd_reg, ex_rd_next;
    logic [7:0] ex_a_reg, ex_a_next;
    logic [7:0] ex_b_reg, ex_b_next;
    logic [7:0] ex_sdata_reg, ex_sdata_next;
    logic [7:0] ex_npc_reg, ex_npc_next;

    logic [3:0] op;
    assign op = bus.instr_in[19:16];

    // decode: the slot behind a redirect pulse is squashed to a bubble
    always_comb begin
        jump_sel_next  = 1'b0;
        jump_addr_next = 8'h00;
        illegal_next   = 1'b0;
        ex_valid_next  = 1'b0;
        ex_op_next     = OP_NOP;
        ex_rd_next     = 4'd0;
        ex_a_next      = 8'h00;
        ex_b_next      = 8'h00;
        ex_sdata_next  = 8'h00;
        ex_npc_next    = bus.npc_in;
        if (!jump_sel_reg) begin
            case (op)
                OP_NOP: ;
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    ex_valid_next = 1'b1;
                    ex_op_next    = op;
                    ex_rd_next    = bus.instr_in[15:12];
                    ex_a_next     = rd_val[0];
                    ex_b_next     = rd_val[1];
                end
                OP_ADDI, OP_LD: begin
                    ex_valid_next = 1'b1;
                    ex_op_next    = op;
                    ex_rd_next    = bus.instr_in[15:12];
                    ex_a_next     = rd_val[0];
                    ex_b_next     = bus.instr_in[7:0];
                end
                OP_ST: begin
                    // [15:12] is the data source, not a destination
                    ex_valid_next = 1'b1;
                    ex_op_next    = op;
                    ex_a_next     = rd_val[0];
                    ex_b_next     = bus.instr_in[7:0];
                    ex_sdata_next = rd_val[2];
                end
                OP_JMP: begin
                    ex_valid_next  = 1'b1;
                    ex_op_next     = op;
                    jump_sel_next  = 1'b1;
                    jump_addr_next = bus.instr_in[7:0];
                end
                OP_BEQZ: begin
                    ex_valid_next = 1'b1;
                    ex_op_next    = op;
                    if (rd_val[0] == 8'h00) begin
                        jump_sel_next  = 1'b1;
                        jump_addr_next = bus.instr_in[7:0];
                    end
                end
                default: begin
                    // reserved opcode: bubble plus one-cycle flag
                    illegal_next = 1'b1;
                end
            endcase
        end
    end

    // ID/EX and redirect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_sel_reg  <= 1'b0;
            jump_addr_reg <= 8'h00;
            illegal_reg   <= 1'b0;
            ex_valid_reg  <= 1'b0;
            ex_op_reg     <= 4'd0;
            ex_rd_reg     <= 4'd0;
            ex_a_reg      <= 8'h00;
            ex_b_reg      <= 8'h00;
            ex_sdata_reg  <= 8'h00;
            ex_npc_reg    <= 8'h00;
        end else begin
            jump_sel_reg  <= jump_sel_next;
            jump_addr_reg <= jump_addr_next;
            illegal_reg   <= illegal_next;
            ex_valid_reg  <= ex_valid_next;
            ex_op_reg     <= ex_op_next;
            ex_rd_reg     <= ex_rd_next;
            ex_a_reg      <= ex_a_next;
            ex_b_reg      <= ex_b_next;
            ex_sdata_reg  <= ex_sdata_next;
            ex_npc_reg    <= ex_npc_next;
        end
    end

    assign bus.jump_selector = jump_sel_reg;
    assign bus.jump_address  = jump_addr_reg;
    assign bus.illegal       = illegal_reg;
    assign bus.ex_valid      = ex_valid_reg;
    assign bus.ex_op         = ex_op_reg;
    assign bus.ex_rd         = ex_rd_reg;
    assign bus.ex_a          = ex_a_reg;
    assign bus.ex_b          = ex_b_reg;
    assign bus.ex_sdata      = ex_sdata_reg;
    assign bus.ex_npc        = ex_npc_reg;
endmodule

// File: tb/tb_id_unit.sv
// tb_id_unit: directed scenarios plus a randomized run checked against a
// rule-level model of the decode stage (register array + squash flag).
`timescale 1ns/1ps
module tb_id_unit;
`ifdef ID_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_unit_if bus();
    id_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [7:0] m_regs [16];
    bit         m_squash;

    // all outputs packed: jsel, jaddr, illegal, valid, op, rd, a, b, sdata, npc
    function automatic logic [50:0] obs();
        return {bus.jump_selector, bus.jump_address, bus.illegal, bus.ex_valid,
                bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b, bus.ex_sdata, bus.ex_npc};
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a, input logic we,
                                          input logic [3:0] wa, input logic [7:0] wd);
        if (a == 4'd0) return 8'h00;
        if (BYPASS && we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    // expected outputs one cycle after presenting these inputs
    function automatic logic [50:0] predict(input logic [19:0] ins, input logic [7:0] npc,
                                            input logic we, input logic [3:0] wa,
                                            input logic [7:0] wd);
        int         op;
        logic       js, il, v;
        logic [7:0] ja, a, b, sd;
        logic [3:0] rd;
        op = int'(ins[19:16]);
        js = 0; il = 0; v = 0; ja = 0; a = 0; b = 0; sd = 0; rd = 0;
        if (!m_squash) begin
            if (op >= 1 && op <= 4) begin
                v = 1; rd = ins[15:12];
                a = m_read(ins[11:8], we, wa, wd); b = m_read(ins[7:4], we, wa, wd);
            end else if (op == 5 || op == 6) begin
                v = 1; rd = ins[15:12]; a = m_read(ins[11:8], we, wa, wd); b = ins[7:0];
            end else if (op == 7) begin
                v = 1; a = m_read(ins[11:8], we, wa, wd); b = ins[7:0];
                sd = m_read(ins[15:12], we, wa, wd);
            end else if (op == 8) begin
                v = 1; js = 1; ja = ins[7:0];
            end else if (op == 9) begin
                v = 1;
                if (m_read(ins[11:8], we, wa, wd) == 8'h00) begin js = 1; ja = ins[7:0]; end
            end else if (op >= 10) begin
                il = 1;
            end
        end
        return {js, ja, il, v, (v ? ins[19:16] : 4'd0), rd, a, b, sd, npc};
    endfunction

    // present inputs at a negedge, return at the next negedge (one capture later)
    task automatic drive(input logic [19:0] ins, input logic [7:0] npc, input logic we,
                         input logic [3:0] wa, input logic [7:0] wd);
        bus.instr_in = ins; bus.npc_in = npc;
        bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(20'h00000, 8'h00, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_in = 20'h11600; bus.npc_in = 8'h33;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd6; bus.wb_data = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== 51'd0) $display("FAIL reset_outputs got=%h want=0", obs());
        else passed++;
        rst_n = 1'b1;
        // wb_en held during reset must not have written r6
        drive(20'h11600, 8'h01, 1'b0, 4'd0, 8'h00);
        total++;
        if (bus.ex_a !== 8'h00) $display("FAIL reset_wb_ignored ex_a=%h want=00", bus.ex_a);
        else passed++;
    endtask

    task automatic test_alu();
        nop();
        drive(20'h00000, 8'h00, 1'b1, 4'd3, 8'h2A);
        drive(20'h11300, 8'h07, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b} !== {1'b1, 4'd1, 4'd1, 8'h2A, 8'h00})
            $display("FAIL add_decode got v=%b op=%h rd=%h a=%h b=%h want v=1 op=1 rd=1 a=2a b=00",
                     bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b);
        else passed++;
    endtask

    task automatic test_jmp();
        nop();
        drive(20'h8000C, 8'd5, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.jump_selector, bus.jump_address, bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_npc}
            !== {1'b1, 8'd12, 1'b1, 4'd8, 4'd0, 8'd5})
            $display("FAIL jmp_pulse got js=%b ja=%0d v=%b op=%h rd=%h npc=%0d want js=1 ja=12 v=1 op=8 rd=0 npc=5",
                     bus.jump_selector, bus.jump_address, bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_npc);
        else passed++;
        drive(20'h11300, 8'd6, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.jump_selector, bus.ex_valid, bus.ex_op, bus.ex_npc} !== {1'b0, 1'b0, 4'd0, 8'd6})
            $display("FAIL jmp_squash got js=%b v=%b op=%h npc=%0d want js=0 v=0 op=0 npc=6",
                     bus.jump_selector, bus.ex_valid, bus.ex_op, bus.ex_npc);
        else passed++;
    endtask

    task automatic test_beqz();
        nop();
        drive(20'h00000, 8'h00, 1'b1, 4'd2, 8'h00);
        drive(20'h90228, 8'h10, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.jump_selector, bus.jump_address} !== {1'b1, 8'd40})
            $display("FAIL beqz_taken got js=%b ja=%0d want js=1 ja=40", bus.jump_selector, bus.jump_address);
        else passed++;
        drive(20'h00000, 8'h00, 1'b1, 4'd2, 8'h07);
        drive(20'h90228, 8'h11, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.jump_selector, bus.ex_valid, bus.ex_op} !== {1'b0, 1'b1, 4'd9})
            $display("FAIL beqz_not_taken got js=%b v=%b op=%h want js=0 v=1 op=9",
                     bus.jump_selector, bus.ex_valid, bus.ex_op);
        else passed++;
    endtask

    task automatic test_bypass();
        nop();
        drive(20'h00000, 8'h00, 1'b1, 4'd4, 8'h05);
        drive(20'h90433, 8'h20, 1'b1, 4'd4, 8'h00);
        total++;
        if (bus.jump_selector !== BYPASS)
            $display("FAIL beqz_bypass js=%b want=%b", bus.jump_selector, BYPASS);
        else passed++;
        nop();
    endtask

    task automatic test_illegal();
        nop();
        drive(20'hC0000, 8'h30, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.illegal, bus.ex_valid, bus.ex_npc} !== {1'b1, 1'b0, 8'h30})
            $display("FAIL illegal_flag got ill=%b v=%b npc=%h want ill=1 v=0 npc=30",
                     bus.illegal, bus.ex_valid, bus.ex_npc);
        else passed++;
        nop();
        total++;
        if (bus.illegal !== 1'b0) $display("FAIL illegal_one_cycle ill=%b want=0", bus.illegal);
        else passed++;
        drive(20'h80050, 8'h31, 1'b0, 4'd0, 8'h00);
        drive(20'hC0000, 8'h32, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.illegal, bus.ex_valid, bus.jump_selector} !== 3'b000)
            $display("FAIL illegal_in_squash got ill=%b v=%b js=%b want 0 0 0",
                     bus.illegal, bus.ex_valid, bus.jump_selector);
        else passed++;
    endtask

    task automatic test_back_to_back();
        nop();
        drive(20'h8000A, 8'h40, 1'b0, 4'd0, 8'h00);
        drive(20'h80014, 8'h41, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.jump_selector, bus.ex_valid} !== 2'b00)
            $display("FAIL b2b_second_squashed got js=%b v=%b want 0 0", bus.jump_selector, bus.ex_valid);
        else passed++;
        nop();
        total++;
        if (bus.jump_selector !== 1'b0)
            $display("FAIL b2b_no_late_pulse js=%b want=0", bus.jump_selector);
        else passed++;
    endtask

    task automatic test_reset_mid_jump();
        nop();
        drive(20'h80077, 8'h50, 1'b0, 4'd0, 8'h00);
        total++;
        if (bus.jump_selector !== 1'b1) $display("FAIL midjump_pulse js=%b want=1", bus.jump_selector);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 51'd0) $display("FAIL async_reset got=%h want=0", obs());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(20'h51005, 8'h51, 1'b0, 4'd0, 8'h00);
        total++;
        if ({bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b, bus.jump_selector}
            !== {1'b1, 4'd5, 4'd1, 8'h00, 8'h05, 1'b0})
            $display("FAIL after_reset_addi got v=%b op=%h rd=%h a=%h b=%h js=%b want v=1 op=5 rd=1 a=00 b=05 js=0",
                     bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b, bus.jump_selector);
        else passed++;
    endtask

    task automatic test_random();
        logic [19:0] ins;
        logic [7:0]  npc, wd;
        logic [3:0]  wa;
        logic        we;
        logic [50:0] exp_v;
        // start from a clean, known state
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_squash = 0;
        for (int n = 0; n < 300; n++) begin
            ins = 20'($urandom);
            npc = 8'($urandom);
            we  = 1'($urandom);
            wa  = 4'($urandom);
            wd  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            exp_v = predict(ins, npc, we, wa, wd);
            drive(ins, npc, we, wa, wd);
            m_squash = exp_v[50];
            if (we && wa != 4'd0) m_regs[wa] = wd;
            total++;
            if (obs() !== exp_v)
                $display("FAIL random[%0d] instr=%h got=%h want=%h", n, ins, obs(), exp_v);
            else passed++;
        end
    endtask

    initial begin
        bus.instr_in = '0; bus.npc_in = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        test_reset();
        test_alu();
        test_jmp();
        test_beqz();
        test_bypass();
        test_illegal();
        test_back_to_back();
        test_reset_mid_jump();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
